// File: rtl/reg_display_scheduler_pkg.sv
// rtl/reg_display_scheduler_pkg.sv - shared char codes, state enum and glyph geometry
package disp_pkg;

  localparam int GLYPH_W    = 8;
  localparam int GLYPH_H    = 8;
  localparam int GLYPH_COLS = 8;

  localparam logic [7:0] CH_HEX0  = 8'd0;
  localparam logic [7:0] CH_HEXF  = 8'd15;
  localparam logic [7:0] CH_R     = 8'd16;
  localparam logic [7:0] CH_COLON = 8'd17;
  localparam logic [7:0] CH_SPACE = 8'd18;

  typedef enum logic [1:0] {IDLE, LOAD, DRAW} state_t;

  // Hex nibble to its glyph code (codes 0..15 are the hex digits).
  function automatic logic [7:0] hex_code(input logic [3:0] n);
    return CH_HEX0 + {4'h0, n};
  endfunction

endpackage

// File: rtl/reg_display_scheduler_if.sv
// rtl/reg_display_scheduler_if.sv - CPU write port plus VGA plot port bundle
interface reg_display_scheduler_if #(
  parameter int IDX_W  = 3,
  parameter int DATA_W = 16
);
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic              refresh;
  logic              plot_ready;
  logic              plot;
  logic [9:0]        x;
  logic [9:0]        y;
  logic [2:0]        color;
  logic              busy;

  // Scheduler side: consumes CPU writes, drives pixels toward the adapter.
  modport master (
    input  wr_en, wr_idx, wr_data, refresh, plot_ready,
    output plot, x, y, color, busy
  );

  // Environment side: CPU and VGA adapter.
  modport slave (
    output wr_en, wr_idx, wr_data, refresh, plot_ready,
    input  plot, x, y, color, busy
  );
endinterface

// File: rtl/reg_display_scheduler_glyph_rom.sv
// rtl/reg_display_scheduler_glyph_rom.sv - combinational 8x8 font, row r in bits [8r+7:8r]
module glyph_rom_8x8
  import disp_pkg::*;
(
  input  logic [7:0]                 code,
  output logic [GLYPH_W*GLYPH_H-1:0] bitmap
);

  // Rows are listed top to bottom; row 0 lands in the low byte.
  function automatic logic [63:0] rows(input logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7);
    return {r7, r6, r5, r4, r3, r2, r1, r0};
  endfunction

  // Font lookup; unknown codes render blank.
  always_comb begin
    bitmap = '0;
    case (code)
      8'd0:     bitmap = rows(8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00);
      8'd1:     bitmap = rows(8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00);
      8'd2:     bitmap = rows(8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00);
      8'd3:     bitmap = rows(8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00);
      8'd4:     bitmap = rows(8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00);
      8'd5:     bitmap = rows(8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00);
      8'd6:     bitmap = rows(8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00);
      8'd7:     bitmap = rows(8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00);
      8'd8:     bitmap = rows(8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00);
      8'd9:     bitmap = rows(8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00);
      8'd10:    bitmap = rows(8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00);
      8'd11:    bitmap = rows(8'h7C, 8'h66, 8'h66, 8'h7C, 8'h66, 8'h66, 8'h7C, 8'h00);
      8'd12:    bitmap = rows(8'h3C, 8'h66, 8'h60, 8'h60, 8'h60, 8'h66, 8'h3C, 8'h00);
      8'd13:    bitmap = rows(8'h78, 8'h6C, 8'h66, 8'h66, 8'h66, 8'h6C, 8'h78, 8'h00);
      8'd14:    bitmap = rows(8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h7E, 8'h00);
      8'd15:    bitmap = rows(8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h60, 8'h00);
      CH_R:     bitmap = rows(8'h7C, 8'h66, 8'h66, 8'h7C, 8'h78, 8'h6C, 8'h66, 8'h00);
      CH_COLON: bitmap = rows(8'h00, 8'h18, 8'h18, 8'h00, 8'h18, 8'h18, 8'h00, 8'h00);
      default:  bitmap = '0;
    endcase
  end

endmodule

// File: rtl/reg_display_scheduler.sv
// rtl/reg_display_scheduler.sv - shadows CPU register writes and redraws dirty panel rows
module reg_display_scheduler
  import disp_pkg::*;
#(
  parameter int NUM_REGS  = 8,
  parameter int DATA_W    = 16,
  parameter int X0        = 10,
  parameter int Y0        = 10,
  parameter int COL_PITCH = 9,
  parameter int ROW_PITCH = 15
) (
  input logic                    clock,
  input logic                    reset,
  reg_display_scheduler_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REGS);

  state_t            state, state_nx;
  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic [NUM_REGS-1:0] dirty;
  logic [IDX_W-1:0]  rr_ptr, sel, cand, row, n_row;
  logic [DATA_W-1:0] snap, n_snap;
  logic [2:0]        px, py, col, n_px, n_py, n_col;
  logic              found, accept, last, n_bit;
  logic [7:0]        code;
  logic [63:0]       bitmap;
  logic [9:0]        pix_x, pix_y, x_q, y_q;
  logic [2:0]        color_q;
  logic              plot_q;

  assign accept   = (state == DRAW) && plot_q && bus.plot_ready;
  assign last     = accept && (px == 3'(GLYPH_W - 1)) && (py == 3'(GLYPH_H - 1))
                    && (col == 3'(GLYPH_COLS - 1));
  assign bus.plot  = plot_q;
  assign bus.x     = x_q;
  assign bus.y     = y_q;
  assign bus.color = color_q;
  assign bus.busy  = (state != IDLE);

  // Round-robin arbiter: first dirty row after the last one served.
  always_comb begin
    sel   = rr_ptr;
    cand  = rr_ptr;
    found = 1'b0;
    for (int i = 1; i <= NUM_REGS; i++) begin
      cand = rr_ptr + IDX_W'(i);
      if (!found && dirty[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|dirty) state_nx = LOAD;
      LOAD:    state_nx = DRAW;
      DRAW:    if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Counters for the pixel that will be on the outputs after this edge.
  always_comb begin
    n_px   = px;
    n_py   = py;
    n_col  = col;
    n_row  = row;
    n_snap = snap;
    if (state == LOAD) begin
      {n_col, n_py, n_px} = '0;
      n_row  = sel;
      n_snap = shadow[sel];
    end else if (accept) begin
      {n_col, n_py, n_px} = {col, py, px} + 9'd1;
    end
  end

  // Glyph selection for the column being drawn.
  always_comb begin
    code = CH_SPACE;
    case (n_col)
      3'd0: code = CH_R;
      3'd1: code = hex_code(4'(n_row));
      3'd2: code = CH_COLON;
      3'd3: code = CH_SPACE;
      3'd4: code = hex_code(n_snap[15:12]);
      3'd5: code = hex_code(n_snap[11:8]);
      3'd6: code = hex_code(n_snap[7:4]);
      3'd7: code = hex_code(n_snap[3:0]);
      default: code = CH_SPACE;
    endcase
  end

  glyph_rom_8x8 u_rom (
    .code   (code),
    .bitmap (bitmap)
  );

  // Leftmost pixel is the glyph row's MSB, hence the inverted px.
  assign n_bit = bitmap[{n_py, ~n_px}];
  assign pix_x = 10'(X0) + 10'(n_col) * 10'(COL_PITCH) + 10'(n_px);
  assign pix_y = 10'(Y0) + 10'(n_row) * 10'(ROW_PITCH) + 10'(n_py);

  // Pixel counters and registered plot outputs; they move only on LOAD or an accepted pixel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      px <= '0; py <= '0; col <= '0; row <= '0; snap <= '0;
      plot_q <= 1'b0; x_q <= '0; y_q <= '0; color_q <= '0;
    end else if (state == LOAD || accept) begin
      px <= n_px; py <= n_py; col <= n_col; row <= n_row; snap <= n_snap;
      plot_q <= !last;
      if (!last) begin
        x_q     <= pix_x;
        y_q     <= pix_y;
        color_q <= n_bit ? 3'b111 : 3'b000;
      end
    end
  end

  // Shadow copy and dirty bits; a fresh write or refresh overrides LOAD's clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
      dirty  <= '1;
      rr_ptr <= IDX_W'(NUM_REGS - 1);
    end else begin
      if (state == LOAD) begin
        dirty[sel] <= 1'b0;
        rr_ptr     <= sel;
      end
      if (bus.refresh) dirty <= '1;
      if (bus.wr_en) begin
        shadow[bus.wr_idx] <= bus.wr_data;
        dirty[bus.wr_idx]  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_display_scheduler.sv
// tb/tb_reg_display_scheduler.sv - directed self-checking bench for reg_display_scheduler
module tb_reg_display_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   stall_errs = 0;
  logic rand_ready = 1'b0;

  logic [9:0]  qx [$];
  logic [9:0]  qy [$];
  logic [2:0]  qc [$];
  logic [15:0] exp_val [8];

  logic [7:0] font [19][8] = '{
    '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
    '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
    '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
    '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},
    '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
    '{8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00},
    '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00},
    '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00},
    '{8'h7C, 8'h66, 8'h66, 8'h7C, 8'h66, 8'h66, 8'h7C, 8'h00},
    '{8'h3C, 8'h66, 8'h60, 8'h60, 8'h60, 8'h66, 8'h3C, 8'h00},
    '{8'h78, 8'h6C, 8'h66, 8'h66, 8'h66, 8'h6C, 8'h78, 8'h00},
    '{8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h7E, 8'h00},
    '{8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h60, 8'h00},
    '{8'h7C, 8'h66, 8'h66, 8'h7C, 8'h78, 8'h6C, 8'h66, 8'h00},
    '{8'h00, 8'h18, 8'h18, 8'h00, 8'h18, 8'h18, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}
  };

  reg_display_scheduler_if #(.IDX_W(3), .DATA_W(16)) bus ();

  reg_display_scheduler #(
    .NUM_REGS(8), .DATA_W(16), .X0(10), .Y0(10), .COL_PITCH(9), .ROW_PITCH(15)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Adapter model: ready changes shortly after each rising edge.
  initial begin
    bus.plot_ready = 1'b1;
    forever begin
      @(posedge clock);
      #2;
      bus.plot_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Pixel monitor: records accepted pixels, flags any output change while stalled.
  initial begin
    logic        stalled;
    logic [22:0] held;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clock);
      if (!reset && bus.plot) begin
        if (stalled && ({bus.x, bus.y, bus.color} !== held)) stall_errs++;
        if (bus.plot_ready) begin
          qx.push_back(bus.x);
          qy.push_back(bus.y);
          qc.push_back(bus.color);
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = {bus.x, bus.y, bus.color};
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic cpu_write(input int idx, input logic [15:0] d);
    @(posedge clock);
    #2;
    bus.wr_en   = 1'b1;
    bus.wr_idx  = idx[2:0];
    bus.wr_data = d;
    exp_val[idx] = d;
    @(posedge clock);
    #2;
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_refresh();
    @(posedge clock);
    #2;
    bus.refresh = 1'b1;
    @(posedge clock);
    #2;
    bus.refresh = 1'b0;
  endtask

  // Waits for one full row of accepted pixels and compares it to the font model.
  task automatic check_row(input int r);
    int waited, errs, first_bad, col, py, px;
    logic [15:0] v;
    logic [7:0]  code;
    logic [9:0]  ex, ey;
    logic [2:0]  ec, gx, gy, gc;
    logic [9:0]  bx, by;
    v = exp_val[r];
    waited = 0;
    while (qx.size() < 512 && waited < 3000) begin
      @(negedge clock);
      waited++;
    end
    checks++;
    assert (qx.size() >= 512)
      else begin errors++; $error("FAIL row%0d_count got %0d pixels need 512", r, qx.size()); end
    if (qx.size() >= 512) begin
      checks++;
      assert (qx[0] === 10'd10 && qy[0] === 10'(10 + r * 15))
        else begin
          errors++;
          $error("FAIL row%0d_first_xy got x=%0d y=%0d need x=10 y=%0d", r, qx[0], qy[0], 10 + r * 15);
        end
      errs = 0;
      first_bad = -1;
      bx = '0; by = '0; gc = '0; gx = '0; gy = '0;
      for (int k = 0; k < 512; k++) begin
        col = k / 64;
        py  = (k / 8) % 8;
        px  = k % 8;
        case (col)
          0: code = 8'd16;
          1: code = 8'(r);
          2: code = 8'd17;
          3: code = 8'd18;
          4: code = {4'h0, v[15:12]};
          5: code = {4'h0, v[11:8]};
          6: code = {4'h0, v[7:4]};
          default: code = {4'h0, v[3:0]};
        endcase
        ex = 10'(10 + col * 9 + px);
        ey = 10'(10 + r * 15 + py);
        ec = font[code][py][7 - px] ? 3'b111 : 3'b000;
        if (qx[0] !== ex || qy[0] !== ey || qc[0] !== ec) begin
          if (first_bad < 0) begin
            first_bad = k; bx = qx[0]; by = qy[0]; gc = qc[0];
            gx = 3'(col); gy = 3'(py);
          end
          errs++;
        end
        void'(qx.pop_front());
        void'(qy.pop_front());
        void'(qc.pop_front());
      end
      checks++;
      assert (errs == 0)
        else begin
          errors++;
          $error("FAIL row%0d_pixels value %h: %0d bad, first at %0d (col %0d py %0d) got x=%0d y=%0d c=%0d",
                 r, v, errs, first_bad, gx, gy, bx, by, gc);
        end
    end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_data = '0; bus.refresh = 1'b0;
    for (int i = 0; i < 8; i++) exp_val[i] = 16'h0000;

    // Reset state.
    #1;
    checks++; assert (bus.plot === 1'b0)   else begin errors++; $error("FAIL rst_plot got %b need 0", bus.plot); end
    checks++; assert (bus.x === 10'd0)     else begin errors++; $error("FAIL rst_x got %0d need 0", bus.x); end
    checks++; assert (bus.y === 10'd0)     else begin errors++; $error("FAIL rst_y got %0d need 0", bus.y); end
    checks++; assert (bus.color === 3'd0)  else begin errors++; $error("FAIL rst_color got %0d need 0", bus.color); end
    checks++; assert (bus.busy === 1'b0)   else begin errors++; $error("FAIL rst_busy got %b need 0", bus.busy); end
    #22;
    reset = 1'b0;

    // Full panel after reset, rows 0..7 showing 0000.
    for (int r = 0; r < 8; r++) check_row(r);
    repeat (4) @(posedge clock);

    // Write at idle: two-edge latency to first plot.
    cpu_write(3, 16'hBEEF);
    checks++; assert (bus.busy === 1'b0 && bus.plot === 1'b0)
      else begin errors++; $error("FAIL lat_k busy=%b plot=%b need 0 0", bus.busy, bus.plot); end
    @(posedge clock); #1;
    checks++; assert (bus.busy === 1'b1 && bus.plot === 1'b0)
      else begin errors++; $error("FAIL lat_load busy=%b plot=%b need 1 0", bus.busy, bus.plot); end
    @(posedge clock); #1;
    checks++; assert (bus.plot === 1'b1 && bus.x === 10'd10 && bus.y === 10'd55)
      else begin errors++; $error("FAIL lat_draw plot=%b x=%0d y=%0d need 1 10 55", bus.plot, bus.x, bus.y); end
    check_row(3);
    repeat (4) @(posedge clock);

    // Round-robin from row 1: writes to 5 then 2 served as 2 then 5.
    cpu_write(1, 16'hA5C3);
    repeat (20) @(posedge clock);
    cpu_write(5, 16'h0F5A);
    cpu_write(2, 16'h2C9D);
    check_row(1);
    check_row(2);
    check_row(5);
    repeat (4) @(posedge clock);

    // Write to the row being drawn: old value finishes, then redrawn.
    cpu_write(4, 16'hCAFE);
    repeat (100) @(posedge clock);
    @(posedge clock); #2;
    bus.wr_en = 1'b1; bus.wr_idx = 3'd4; bus.wr_data = 16'h1234;
    @(posedge clock); #2;
    bus.wr_en = 1'b0;
    check_row(4);
    exp_val[4] = 16'h1234;
    check_row(4);
    repeat (4) @(posedge clock);

    // Refresh with random backpressure: order resumes after row 4.
    rand_ready = 1'b1;
    pulse_refresh();
    for (int i = 5; i < 13; i++) check_row(i % 8);
    rand_ready = 1'b0;
    checks++; assert (stall_errs == 0)
      else begin errors++; $error("FAIL stall_hold got %0d changes need 0", stall_errs); end
    repeat (4) @(posedge clock);

    // Reset in the middle of a row.
    pulse_refresh();
    repeat (100) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++; assert (bus.plot === 1'b0 && bus.busy === 1'b0 && bus.x === 10'd0)
      else begin errors++; $error("FAIL mid_reset plot=%b busy=%b x=%0d need 0 0 0", bus.plot, bus.busy, bus.x); end
    qx.delete(); qy.delete(); qc.delete();
    for (int i = 0; i < 8; i++) exp_val[i] = 16'h0000;
    repeat (3) @(posedge clock);
    #3;
    reset = 1'b0;
    for (int r = 0; r < 8; r++) check_row(r);

    // Nothing left pending afterwards.
    repeat (20) @(posedge clock);
    #1;
    checks++; assert (qx.size() == 0 && bus.plot === 1'b0 && bus.busy === 1'b0)
      else begin errors++; $error("FAIL final_idle extra=%0d plot=%b busy=%b need 0 0 0", qx.size(), bus.plot, bus.busy); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
